// File: rtl/usb_crc_pkg.sv
// usb_crc_pkg: shared USB CRC polynomials, residues and emit FSM state type
package usb_crc_pkg;
  localparam logic [4:0]  CRC5_POLY     = 5'h05;
  localparam logic [4:0]  CRC5_RESIDUE  = 5'h0C;
  localparam logic [15:0] CRC16_POLY    = 16'h8005;
  localparam logic [15:0] CRC16_RESIDUE = 16'h800D;
  typedef enum logic [1:0] {IDLE, EMIT, DONE} crc_emit_state_t;
endpackage

// File: rtl/usb_crc_lfsr.sv
// usb_crc_lfsr: one-bit combinational CRC next-state function
module usb_crc_lfsr #(
  parameter int              CRC_W = 16,
  parameter logic [CRC_W-1:0] POLY = CRC_W'(16'h8005)
) (
  input  logic [CRC_W-1:0] q,
  input  logic             d,
  output logic [CRC_W-1:0] q_next
);
  assign q_next = {q[CRC_W-2:0], 1'b0} ^ ((d ^ q[CRC_W-1]) ? POLY : '0);
endmodule

// File: rtl/usb_crc_engine.sv
// usb_crc_engine: serial CRC5/CRC16 checker; define USB_CRC_EMIT_EN to add the
// serial CRC appender (emit FSM), otherwise emit outputs are tied low.
module usb_crc_engine
  import usb_crc_pkg::*;
#(
  parameter int               CRC_W   = 16,
  parameter logic [CRC_W-1:0] POLY    = CRC_W'(CRC16_POLY),
  parameter logic [CRC_W-1:0] INIT    = '1,
  parameter logic [CRC_W-1:0] RESIDUE = CRC_W'(CRC16_RESIDUE)
) (
  input  logic             clk,
  input  logic             n_rst,
  input  logic             crc_clear,
  input  logic             shift_enable,
  input  logic             crc_enable,
  input  logic             d_in,
  input  logic             emit_start,
  output logic             crc_ok,
  output logic             crc_out,
  output logic             emit_busy,
  output logic             emit_done,
  output logic [CRC_W-1:0] crc_value
);
  localparam int CNT_W = $clog2(CRC_W);
  logic [CRC_W-1:0] q, q_next;
  logic             upd;
  usb_crc_lfsr #(.CRC_W(CRC_W), .POLY(POLY)) u_lfsr (.q(q), .d(d_in), .q_next(q_next));
`ifdef USB_CRC_EMIT_EN
  crc_emit_state_t  state, state_n;
  logic [CRC_W-1:0] sr, sr_n;
  logic [CNT_W-1:0] cnt, cnt_n;
  assign upd = shift_enable && crc_enable && state == IDLE;
  always_ff @(posedge clk or negedge n_rst)
    if (!n_rst) begin
      state <= IDLE;
      sr    <= '0;
      cnt   <= '0;
    end else begin
      state <= state_n;
      sr    <= sr_n;
      cnt   <= cnt_n;
    end
  // The last strobe exits at cnt == 0 so the counter never wraps
  always_comb begin
    state_n = state;
    sr_n    = sr;
    cnt_n   = cnt;
    if (crc_clear) state_n = IDLE;
    else case (state)
      IDLE: if (emit_start) begin
        state_n = EMIT;
        sr_n    = ~q;
        cnt_n   = CNT_W'(CRC_W - 1);
      end
      EMIT: if (shift_enable) begin
        sr_n    = {sr[CRC_W-2:0], 1'b0};
        cnt_n   = (cnt == '0) ? cnt : cnt - 1'b1;
        state_n = (cnt == '0) ? DONE : EMIT;
      end
      default: state_n = IDLE;
    endcase
  end
  assign crc_out   = (state == EMIT) && sr[CRC_W-1];
  assign emit_busy = state == EMIT;
  assign emit_done = state == DONE;
`else
  logic unused_emit_start;
  assign unused_emit_start = emit_start;
  assign upd       = shift_enable && crc_enable;
  assign crc_out   = 1'b0;
  assign emit_busy = 1'b0;
  assign emit_done = 1'b0;
`endif
  always_ff @(posedge clk or negedge n_rst)
    if (!n_rst) q <= INIT;
    else q <= crc_clear ? INIT : upd ? q_next : q;
  assign crc_ok    = q == RESIDUE;
  assign crc_value = q;
endmodule

// File: tb/tb_usb_crc_engine.sv
// tb_usb_crc_engine: directed checks of CRC16 and CRC5 instances; emit tests
// are compiled only when USB_CRC_EMIT_EN is defined.
module tb_usb_crc_engine;
  logic clk = 1'b0, n_rst = 1'b0;
  logic crc_clear = 0, shift_enable = 0, crc_enable = 0, d_in = 0, emit_start = 0;
  logic ok16, out16, busy16, done16, ok5, out5, busy5, done5;
  logic [15:0] val16;
  logic [4:0]  val5;
  int checks = 0, errors = 0;
  logic [15:0] crc, bits;
  int n;
  localparam logic [31:0] PAYLOAD = 32'hA5C3_1E96;
  localparam logic [31:0] TOKEN   = 32'h0000_05A3;

  always #5 clk = ~clk;

  usb_crc_engine u16 (.clk(clk), .n_rst(n_rst), .crc_clear(crc_clear), .shift_enable(shift_enable),
    .crc_enable(crc_enable), .d_in(d_in), .emit_start(emit_start), .crc_ok(ok16), .crc_out(out16),
    .emit_busy(busy16), .emit_done(done16), .crc_value(val16));
  usb_crc_engine #(.CRC_W(5), .POLY(5'h05), .INIT(5'h1F), .RESIDUE(5'h0C)) u5 (.clk(clk),
    .n_rst(n_rst), .crc_clear(crc_clear), .shift_enable(shift_enable), .crc_enable(crc_enable),
    .d_in(d_in), .emit_start(emit_start), .crc_ok(ok5), .crc_out(out5), .emit_busy(busy5),
    .emit_done(done5), .crc_value(val5));

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic cyc(input logic se, input logic ce, input logic d, input logic es, input logic clr);
    shift_enable = se; crc_enable = ce; d_in = d; emit_start = es; crc_clear = clr;
    @(posedge clk); #1;
    shift_enable = 0; crc_enable = 0; d_in = 0; emit_start = 0; crc_clear = 0;
  endtask

  task automatic feed(input logic [31:0] m, input int len);
    for (int i = 0; i < len; i++) cyc(1, 1, m[len-1-i], 0, 0);
  endtask

  // Polynomial long division of M*x^w + INIT*x^n by the full generator
  function automatic logic [15:0] model(input logic [31:0] m, input int len, input int w,
                                        input logic [15:0] poly);
    logic [63:0] v, g;
    v = 64'(m) << w;
    for (int i = 0; i < w; i++) v[len+w-1-i] = ~v[len+w-1-i];
    g = (64'd1 << w) | 64'(poly);
    for (int i = len + w - 1; i >= w; i--) if (v[i]) v = v ^ (g << (i - w));
    return 16'(v & ((64'd1 << w) - 1));
  endfunction

`ifdef USB_CRC_EMIT_EN
  task automatic emit(input int w, input logic se0, input int es_at, output logic [15:0] b,
                      output int cnt);
    b = '0; cnt = 0;
    cyc(se0, 0, 0, 1, 0);
    while (!(w == 5 ? done5 : done16) && cnt < 40) begin
      if (cnt == es_at) cyc(0, 0, 0, 1, 0);
      b = {b[14:0], (w == 5 ? out5 : out16)};
      cyc(1, 1, 1, 0, 0);
      cnt++;
    end
    chk($sformatf("strobes_w%0d", w), 16'(cnt), 16'(w));
    chk($sformatf("done_pulse_w%0d", w), {15'h0, (w == 5 ? done5 : done16)}, 16'h1);
    cyc(0, 0, 0, 0, 0);
    chk($sformatf("done_clear_w%0d", w), {14'h0, (w == 5 ? done5 : done16),
        (w == 5 ? busy5 : busy16)}, 16'h0);
  endtask
`endif

  initial begin
    #12;
    chk("rst_val16", val16, 16'hFFFF);
    chk("rst_val5", {11'h0, val5}, 16'h001F);
    chk("rst_flags16", {12'h0, ok16, out16, busy16, done16}, 16'h0);
    @(posedge clk); #1 n_rst = 1;
    cyc(1, 1, 0, 0, 0);
    chk("hand16_d0", val16, 16'h7FFB);
    chk("hand5_d0", {11'h0, val5}, 16'h001B);
    cyc(0, 0, 0, 0, 1);
    chk("clear16", val16, 16'hFFFF);
    cyc(1, 0, 1, 0, 0);
    chk("hold_no_ce", val16, 16'hFFFF);
    cyc(0, 1, 1, 0, 0);
    chk("hold_no_se", val16, 16'hFFFF);
    cyc(1, 1, 1, 0, 1);
    chk("clear_priority", val16, 16'hFFFF);
    cyc(1, 1, 1, 0, 0);
    chk("hand16_d1", val16, 16'hFFFE);

    cyc(0, 0, 0, 0, 1);
    feed(PAYLOAD, 32);
    crc = model(PAYLOAD, 32, 16, 16'h8005);
    chk("payload_crc16", val16, crc);
`ifdef USB_CRC_EMIT_EN
    emit(16, 0, -1, bits, n);
    chk("emit_bits16", bits, ~crc);
    chk("frozen16", val16, crc);
`else
    bits = ~crc;
`endif
    cyc(0, 0, 0, 0, 1);
    feed(PAYLOAD, 32);
    feed({16'h0, bits}, 16);
    chk("good_ok16", {15'h0, ok16}, 16'h1);
    chk("good_res16", val16, 16'h800D);
    cyc(0, 0, 0, 0, 1);
    feed(PAYLOAD ^ 32'h0000_0200, 32);
    feed({16'h0, bits}, 16);
    chk("bad_ok16", {15'h0, ok16}, 16'h0);

    cyc(0, 0, 0, 0, 1);
    feed(TOKEN, 11);
    crc = model(TOKEN, 11, 5, 16'h0005);
    chk("token_crc5", {11'h0, val5}, crc);
`ifdef USB_CRC_EMIT_EN
    emit(5, 0, -1, bits, n);
    chk("emit_bits5", bits & 16'h1F, ~crc & 16'h1F);
`else
    bits = ~crc & 16'h1F;
`endif
    cyc(0, 0, 0, 0, 1);
    feed(TOKEN, 11);
    feed({16'h0, bits} & 32'h1F, 5);
    chk("good_ok5", {15'h0, ok5}, 16'h1);
    chk("good_res5", {11'h0, val5}, 16'h000C);

`ifdef USB_CRC_EMIT_EN
    cyc(0, 0, 0, 0, 1);
    emit(16, 1, -1, bits, n);
    chk("empty_bits16", bits, 16'h0);
    cyc(0, 0, 0, 0, 1);
    emit(5, 0, -1, bits, n);
    chk("empty_bits5", bits & 16'h1F, 16'h0);
    cyc(0, 0, 0, 1, 1);
    chk("clear_beats_start", {15'h0, busy16}, 16'h0);
    cyc(0, 0, 0, 0, 1);
    emit(16, 0, 3, bits, n);
    chk("restart_ignored_bits", bits, 16'h0);
    cyc(0, 0, 0, 0, 1);
    cyc(0, 0, 0, 1, 0);
    for (int i = 0; i < 7; i++) cyc(1, 1, 1, 0, 0);
    chk("busy_mid_emit", {15'h0, busy16}, 16'h1);
    cyc(0, 0, 0, 0, 1);
    chk("abort_flags", {14'h0, busy16, done16}, 16'h0);
    chk("abort_val", val16, 16'hFFFF);
    cyc(0, 0, 0, 0, 0);
    chk("abort_no_done", {15'h0, done16}, 16'h0);
`else
    cyc(0, 0, 0, 0, 1);
    cyc(1, 1, 0, 1, 0);
    chk("noemit_flags", {13'h0, out16, busy16, done16}, 16'h0);
    chk("noemit_not_frozen", val16, 16'h7FFB);
    cyc(1, 1, 1, 0, 0);
    chk("noemit_flags_later", {13'h0, out16, busy16, done16}, 16'h0);
`endif
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
